// File: rtl/snake_body_tracker.sv
// rtl/snake_body_tracker.sv - snake segment list with wrap-around moves, grow, steering and self-collision
module snake_body_tracker #(
  parameter int COORD_W   = 5,
  parameter int MAX_LEN   = 16,
  parameter int START_LEN = 3,
  parameter int START_X   = 16,
  parameter int START_Y   = 16
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic                       step,
  input  logic                       dir_valid,
  input  logic [1:0]                 dir_in,
  input  logic                       grow,
  input  logic                       restart,
  input  logic [$clog2(MAX_LEN)-1:0] rd_idx,
  output logic [COORD_W-1:0]         rd_x,
  output logic [COORD_W-1:0]         rd_y,
  output logic                       rd_valid,
  output logic [COORD_W-1:0]         head_x,
  output logic [COORD_W-1:0]         head_y,
  output logic [$clog2(MAX_LEN):0]   length,
  output logic [1:0]                 heading,
  output logic                       alive,
  output logic                       collision
);

  localparam int IDX_W = $clog2(MAX_LEN);
  localparam int LEN_W = IDX_W + 1;

  typedef enum logic {RUN, DEAD} state_t;

  state_t               state;
  logic [COORD_W-1:0]   seg_x  [MAX_LEN];
  logic [COORD_W-1:0]   seg_y  [MAX_LEN];
  logic [COORD_W-1:0]   init_x [MAX_LEN];
  logic [COORD_W-1:0]   init_y [MAX_LEN];
  logic [1:0]           pending_dir;
  logic                 grow_pend;
  logic [COORD_W-1:0]   nh_x;
  logic [COORD_W-1:0]   nh_y;
  logic                 grow_ok;
  logic [LEN_W-1:0]     limit;
  logic                 hit;

  // Start body: head at START_X, trailing cells to the left (wrapping).
  generate
    for (genvar gi = 0; gi < MAX_LEN; gi++) begin : g_init
      if (gi < START_LEN) begin : g_on
        assign init_x[gi] = COORD_W'(START_X - gi);
        assign init_y[gi] = COORD_W'(START_Y);
      end else begin : g_off
        assign init_x[gi] = '0;
        assign init_y[gi] = '0;
      end
    end
  endgenerate

  always_comb begin
    nh_x = seg_x[0];
    nh_y = seg_y[0];
    case (pending_dir)
      2'd0:    nh_x = seg_x[0] + COORD_W'(1);
      2'd1:    nh_y = seg_y[0] + COORD_W'(1);
      2'd2:    nh_x = seg_x[0] - COORD_W'(1);
      default: nh_y = seg_y[0] - COORD_W'(1);
    endcase
  end

  // Without growth the tail cell vacates this step, so it is excluded from the check.
  always_comb begin
    grow_ok = (grow_pend | grow) && (length < LEN_W'(MAX_LEN));
    limit   = grow_ok ? length : length - LEN_W'(1);
    hit     = 1'b0;
    for (int i = 0; i < MAX_LEN; i++) begin
      if ((LEN_W'(i) < limit) && (seg_x[i] == nh_x) && (seg_y[i] == nh_y))
        hit = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= RUN;
      alive       <= 1'b1;
      collision   <= 1'b0;
      heading     <= 2'd0;
      pending_dir <= 2'd0;
      grow_pend   <= 1'b0;
      length      <= LEN_W'(START_LEN);
      for (int i = 0; i < MAX_LEN; i++) begin
        seg_x[i] <= init_x[i];
        seg_y[i] <= init_y[i];
      end
    end else if (restart) begin
      state       <= RUN;
      alive       <= 1'b1;
      collision   <= 1'b0;
      heading     <= 2'd0;
      pending_dir <= 2'd0;
      grow_pend   <= 1'b0;
      length      <= LEN_W'(START_LEN);
      for (int i = 0; i < MAX_LEN; i++) begin
        seg_x[i] <= init_x[i];
        seg_y[i] <= init_y[i];
      end
    end else if (state == RUN) begin
      if (dir_valid && (dir_in != (heading ^ 2'd2)))
        pending_dir <= dir_in;
      if (step) begin
        grow_pend <= 1'b0;
        if (hit) begin
          state     <= DEAD;
          alive     <= 1'b0;
          collision <= 1'b1;
        end else begin
          for (int i = MAX_LEN - 1; i > 0; i--) begin
            seg_x[i] <= seg_x[i-1];
            seg_y[i] <= seg_y[i-1];
          end
          seg_x[0] <= nh_x;
          seg_y[0] <= nh_y;
          heading  <= pending_dir;
          length   <= length + {{(LEN_W-1){1'b0}}, grow_ok};
        end
      end else if (grow) begin
        grow_pend <= 1'b1;
      end
    end
  end

  assign head_x   = seg_x[0];
  assign head_y   = seg_y[0];
  assign rd_valid = ({1'b0, rd_idx} < length);
  assign rd_x     = rd_valid ? seg_x[rd_idx] : '0;
  assign rd_y     = rd_valid ? seg_y[rd_idx] : '0;

endmodule

// File: tb/tb_snake_body_tracker.sv
// tb/tb_snake_body_tracker.sv - scoreboard bench for snake_body_tracker
module tb_snake_body_tracker;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       step, dir_valid, grow, restart;
  logic [1:0] dir_in;
  logic [3:0] rd_idx;
  logic [4:0] rd_x, rd_y, head_x, head_y;
  logic       rd_valid;
  logic [4:0] length;
  logic [1:0] heading;
  logic       alive, collision;

  snake_body_tracker dut (
    .clock(clock), .reset_n(reset_n), .step(step), .dir_valid(dir_valid),
    .dir_in(dir_in), .grow(grow), .restart(restart), .rd_idx(rd_idx),
    .rd_x(rd_x), .rd_y(rd_y), .rd_valid(rd_valid), .head_x(head_x),
    .head_y(head_y), .length(length), .heading(heading), .alive(alive),
    .collision(collision)
  );

  always #5 clock = ~clock;

  typedef enum {K_HX, K_HY, K_LEN, K_HDG, K_ALIVE, K_COLL, K_RDX, K_RDY, K_RDV} kind_t;
  typedef struct {
    kind_t k;
    int    v;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string tag, input int obs, input int expv);
    n_tests++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, expv, $time);
    end
  endtask

  function automatic int observe(input kind_t k);
    case (k)
      K_HX:    return int'(head_x);
      K_HY:    return int'(head_y);
      K_LEN:   return int'(length);
      K_HDG:   return int'(heading);
      K_ALIVE: return int'(alive);
      K_COLL:  return int'(collision);
      K_RDX:   return int'(rd_x);
      K_RDY:   return int'(rd_y);
      default: return int'(rd_valid);
    endcase
  endfunction

  task automatic expect_val(input kind_t k, input int v);
    exp_t e;
    e.k = k;
    e.v = v;
    exp_q.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check(e.k.name(), observe(e.k), e.v);
    end
  endtask

  task automatic cycle(input logic s, input logic g, input logic dv,
                       input logic [1:0] d, input logic r);
    step = s; grow = g; dir_valid = dv; dir_in = d; restart = r;
    @(posedge clock);
    #1;
    step = 0; grow = 0; dir_valid = 0; dir_in = 0; restart = 0;
    drain();
  endtask

  task automatic expect_head(input int x, input int y);
    expect_val(K_HX, x);
    expect_val(K_HY, y);
  endtask

  initial begin
    reset_n = 0; step = 0; dir_valid = 0; dir_in = 0; grow = 0; restart = 0;
    rd_idx = 4'd2;
    #12;
    expect_head(16, 16);
    expect_val(K_LEN, 3); expect_val(K_HDG, 0); expect_val(K_ALIVE, 1); expect_val(K_COLL, 0);
    expect_val(K_RDX, 14); expect_val(K_RDY, 16); expect_val(K_RDV, 1);
    drain();
    rd_idx = 4'd3;
    #1;
    expect_val(K_RDV, 0); expect_val(K_RDX, 0);
    drain();
    @(negedge clock);
    reset_n = 1;

    // straight run to the right, then wrap at x=31
    rd_idx = 4'd2;
    for (int k = 1; k <= 15; k++) begin
      expect_head(16 + k, 16);
      if (k == 3) begin
        expect_val(K_LEN, 3); expect_val(K_RDX, 17); expect_val(K_RDY, 16);
      end
      cycle(1, 0, 0, 0, 0);
    end
    expect_head(0, 16); expect_val(K_ALIVE, 1);
    cycle(1, 0, 0, 0, 0);

    // reversal rejected, then turn down
    cycle(0, 0, 1, 2'd2, 0);
    expect_head(1, 16); expect_val(K_HDG, 0);
    cycle(1, 0, 0, 0, 0);
    cycle(0, 0, 1, 2'd1, 0);
    expect_head(1, 17); expect_val(K_HDG, 1);
    cycle(1, 0, 0, 0, 0);

    // growth: same-cycle grow, pending grow, then grow to the cap
    expect_val(K_LEN, 4); expect_val(K_HY, 18);
    cycle(1, 1, 0, 0, 0);
    expect_val(K_LEN, 4);
    cycle(0, 1, 0, 0, 0);
    expect_val(K_LEN, 5); expect_val(K_HY, 19);
    cycle(1, 0, 0, 0, 0);
    expect_val(K_LEN, 5); expect_val(K_HY, 20);
    cycle(1, 0, 0, 0, 0);
    for (int k = 6; k <= 16; k++) begin
      expect_val(K_LEN, k); expect_val(K_HY, 15 + k);
      cycle(1, 1, 0, 0, 0);
    end
    expect_val(K_LEN, 16); expect_val(K_HY, 0); expect_val(K_ALIVE, 1);
    cycle(1, 1, 0, 0, 0);
    expect_val(K_LEN, 16); expect_val(K_HY, 1);
    cycle(1, 0, 0, 0, 0);

    // restart from RUN, build length 5, then steer into own body
    expect_head(16, 16); expect_val(K_LEN, 3); expect_val(K_HDG, 0); expect_val(K_ALIVE, 1);
    cycle(0, 0, 0, 0, 1);
    cycle(0, 1, 0, 0, 0);
    expect_val(K_LEN, 4); expect_val(K_HX, 17);
    cycle(1, 0, 0, 0, 0);
    expect_val(K_LEN, 5); expect_val(K_HX, 18);
    cycle(1, 1, 0, 0, 0);
    cycle(0, 0, 1, 2'd1, 0);
    expect_head(18, 17);
    cycle(1, 0, 0, 0, 0);
    cycle(0, 0, 1, 2'd2, 0);
    expect_head(17, 17); expect_val(K_HDG, 2);
    cycle(1, 0, 0, 0, 0);
    cycle(0, 0, 1, 2'd3, 0);
    rd_idx = 4'd4;
    expect_val(K_COLL, 1); expect_val(K_ALIVE, 0); expect_head(17, 17);
    expect_val(K_LEN, 5); expect_val(K_HDG, 2);
    expect_val(K_RDX, 16); expect_val(K_RDY, 16); expect_val(K_RDV, 1);
    cycle(1, 0, 0, 0, 0);
    rd_idx = 4'd5;
    expect_head(17, 17); expect_val(K_COLL, 1); expect_val(K_LEN, 5);
    expect_val(K_RDV, 0); expect_val(K_RDX, 0);
    cycle(1, 1, 1, 2'd0, 0);

    // restart wins over step while DEAD
    expect_val(K_ALIVE, 1); expect_val(K_COLL, 0); expect_head(16, 16);
    expect_val(K_LEN, 3); expect_val(K_HDG, 0);
    cycle(1, 0, 0, 0, 1);
    expect_head(17, 16);
    cycle(1, 0, 0, 0, 0);

    // asynchronous reset mid-run, observed before any clock edge
    reset_n = 0;
    #2;
    expect_head(16, 16); expect_val(K_LEN, 3); expect_val(K_ALIVE, 1); expect_val(K_COLL, 0);
    drain();
    @(negedge clock);
    reset_n = 1;
    expect_head(17, 16);
    cycle(1, 0, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
